// File: rtl/l2_mem_arbiter_pkg.sv
// Shared definitions for the L2 memory arbiter slice.
// Holds the controller state type, the port-owner encoding and the
// default block address/data widths used by the interface and modules.
package l2_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/l2_mem_arbiter_if.sv
// Bus bundle between the I/D cache miss ports, the arbiter and main memory.
// Ports (per side x in {i, d}):
//   x_read/x_write/x_addr/x_wdata  cache -> arbiter request
//   x_rdata/x_ready                arbiter -> cache completion
//   mem_read/mem_write/mem_addr/mem_wdata/mem_owner  arbiter -> memory
//   mem_rdata/mem_ready                               memory -> arbiter
// Modports: master = arbiter view, slave = caches + memory view.
interface l2_mem_arbiter_if
  import l2_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_owner;

  modport master (
    input  i_read, i_write, i_addr, i_wdata,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_owner
  );

  modport slave (
    output i_read, i_write, i_addr, i_wdata,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_owner
  );

endinterface

// File: rtl/l2_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker (purely combinational).
// Ports:
//   req[1:0]    request vector, bit 0 = I side, bit 1 = D side
//   last_grant  side granted most recently
//   grant_sel   selected side; only meaningful when |req
module rr_arb2
  import l2_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_sel
);

  always_comb begin
    grant_sel = ~last_grant;
    case (req)
      2'b01:   grant_sel = OWN_I;
      2'b10:   grant_sel = OWN_D;
      2'b11:   grant_sel = ~last_grant;
      default: grant_sel = ~last_grant;
    endcase
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one block-wide main-memory port between the I-side and D-side
// caches. One transaction at a time: grant in IDLE, hold in BUSY until
// mem_ready, then a single DONE cycle carrying the owner's ready pulse.
// Ports:
//   clk         rising-edge clock
//   proc_reset  synchronous active-high reset, aborts any transaction
//   bus         l2_mem_arbiter_if.master (cache request/response + memory port)
module l2_mem_arbiter
  import l2_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                clk,
  input logic                proc_reset,
  l2_mem_arbiter_if.master   bus
);

  arb_state_t        state, state_n;
  logic              last_grant, last_n;
  logic              own_q, own_n;
  logic              rd_q, rd_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_n;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_n;
  logic              i_rdy_q, i_rdy_n;
  logic              d_rdy_q, d_rdy_n;

  logic [1:0]        req;
  logic              grant_sel;

  assign req = {bus.d_read | bus.d_write, bus.i_read | bus.i_write};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .grant_sel  (grant_sel)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= OWN_D;
      own_q      <= OWN_I;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      own_q      <= own_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      i_rdata_q  <= i_rdata_n;
      d_rdata_q  <= d_rdata_n;
      i_rdy_q    <= i_rdy_n;
      d_rdy_q    <= d_rdy_n;
    end
  end

  always_comb begin
    state_n   = state;
    last_n    = last_grant;
    own_n     = own_q;
    rd_n      = rd_q;
    wr_n      = wr_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    i_rdata_n = i_rdata_q;
    d_rdata_n = d_rdata_q;
    // Ready defaults low so the pulse set on completion clears on DONE exit.
    i_rdy_n   = 1'b0;
    d_rdy_n   = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          own_n = grant_sel;
          if (grant_sel == OWN_D) begin
            wr_n    = bus.d_write;
            rd_n    = bus.d_read & ~bus.d_write;
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
          end else begin
            wr_n    = bus.i_write;
            rd_n    = bus.i_read & ~bus.i_write;
            addr_n  = bus.i_addr;
            wdata_n = bus.i_wdata;
          end
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          rd_n   = 1'b0;
          wr_n   = 1'b0;
          last_n = own_q;
          if (own_q == OWN_D) begin
            d_rdy_n = 1'b1;
            if (rd_q) d_rdata_n = bus.mem_rdata;
          end else begin
            i_rdy_n = 1'b1;
            if (rd_q) i_rdata_n = bus.mem_rdata;
          end
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_owner = own_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_rdy_q;
  assign bus.d_ready   = d_rdy_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: transaction-level reference model
// updated on each rising edge, outputs compared on every falling edge, plus
// directed scenarios with hand-computed expectations.
module tb_l2_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  l2_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  l2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .proc_reset (rst),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction record plus a "ready slot" cycle after it.
  logic          t_active = 1'b0;
  logic          t_owner  = 1'b0;
  logic          t_write  = 1'b0;
  logic          slot     = 1'b0;
  logic          m_last   = 1'b1;
  logic          e_mem_read = 1'b0, e_mem_write = 1'b0, e_own = 1'b0;
  logic          e_i_ready = 1'b0, e_d_ready = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      t_active = 1'b0; t_owner = 1'b0; t_write = 1'b0; slot = 1'b0; m_last = 1'b1;
      e_mem_read = 1'b0; e_mem_write = 1'b0; e_own = 1'b0;
      e_i_ready = 1'b0; e_d_ready = 1'b0;
      e_addr = '0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      e_i_ready = 1'b0;
      e_d_ready = 1'b0;
      if (slot) begin
        slot = 1'b0;
      end else if (t_active) begin
        if (bus.mem_ready) begin
          t_active = 1'b0;
          slot = 1'b1;
          e_mem_read = 1'b0;
          e_mem_write = 1'b0;
          m_last = t_owner;
          if (t_owner) e_d_ready = 1'b1; else e_i_ready = 1'b1;
          if (!t_write) begin
            if (t_owner) e_d_rdata = bus.mem_rdata; else e_i_rdata = bus.mem_rdata;
          end
        end
      end else begin
        logic ri, rd;
        ri = bus.i_read | bus.i_write;
        rd = bus.d_read | bus.d_write;
        if (ri || rd) begin
          t_owner = (ri && rd) ? ~m_last : rd;
          t_active = 1'b1;
          if (t_owner) begin
            t_write = bus.d_write; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
          end else begin
            t_write = bus.i_write; e_addr = bus.i_addr; e_wdata = bus.i_wdata;
          end
          e_mem_write = t_write;
          e_mem_read  = ~t_write;
          e_own = t_owner;
        end
      end
    end
  end

  // ---------------- memory responder / per-cycle compare ----------------
  bit            auto_mem = 1'b0;
  int            mem_lat  = 4;
  int            lat_cnt  = 0;
  logic [DW-1:0] resp_data = '0;
  bit            log_en = 1'b0;
  bit            prev_act = 1'b0;
  logic          own_log [0:15];
  int            log_n = 0;

  task automatic tick();
    @(negedge clk);
    chk("mem_read",  bus.mem_read,  e_mem_read);
    chk("mem_write", bus.mem_write, e_mem_write);
    chk("mem_addr",  bus.mem_addr,  e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("mem_owner", bus.mem_owner, e_own);
    chk("i_ready",   bus.i_ready,   e_i_ready);
    chk("d_ready",   bus.d_ready,   e_d_ready);
    chk("i_rdata",   bus.i_rdata,   e_i_rdata);
    chk("d_rdata",   bus.d_rdata,   e_d_rdata);
    chk("both_ready", bus.i_ready & bus.d_ready, 1'b0);
    chk("rd_and_wr",  bus.mem_read & bus.mem_write, 1'b0);
    if (log_en && (bus.mem_read || bus.mem_write) && !prev_act && log_n < 16) begin
      own_log[log_n] = bus.mem_owner;
      log_n++;
    end
    prev_act = bus.mem_read | bus.mem_write;
    bus.mem_ready = 1'b0;
    if (auto_mem && (bus.mem_read || bus.mem_write)) begin
      lat_cnt++;
      if (lat_cnt == mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = resp_data;
        resp_data = resp_data + 128'd1;
        lat_cnt = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic wait_rdy(input logic side, input string nm, output int n);
    logic r;
    n = 0;
    r = 1'b0;
    while (!r && n < 100) begin
      tick();
      n++;
      r = side ? bus.d_ready : bus.i_ready;
    end
    chk(nm, r, 1'b1);
  endtask

  initial begin
    int n;
    int n_i, n_d;
    logic [5:0] exp_seq;

    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;

    // Reset, then idle; a stray mem_ready in IDLE must be ignored.
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_mem_read", bus.mem_read, 1'b0);
    chk("idle_mem_addr", bus.mem_addr, 28'h0);
    chk("idle_i_rdata",  bus.i_rdata, 128'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hDEAD_BEEF}};
    tick();
    tick();
    chk("stray_i_ready", bus.i_ready, 1'b0);
    chk("stray_d_ready", bus.d_ready, 1'b0);
    chk("stray_i_rdata", bus.i_rdata, 128'h0);

    // I-side read, memory answers after 4 BUSY cycles.
    auto_mem = 1'b1; mem_lat = 4; resp_data = {4{32'h1111_1111}};
    bus.i_read = 1'b1; bus.i_addr = 28'h000_0010;
    tick();
    chk("t2_mem_read", bus.mem_read, 1'b1);
    chk("t2_mem_addr", bus.mem_addr, 28'h000_0010);
    wait_rdy(1'b0, "t2_ready_seen", n);
    chk("t2_latency", n, 4);
    chk("t2_i_rdata", bus.i_rdata, {4{32'h1111_1111}});
    chk("t2_d_ready", bus.d_ready, 1'b0);
    bus.i_read = 1'b0;
    tick();
    chk("t2_i_ready_drop", bus.i_ready, 1'b0);

    // Fresh reset: same-cycle I read and D write, I wins the first tie.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_lat = 3; resp_data = {4{32'h2222_2222}};
    bus.i_read = 1'b1; bus.i_addr = 28'h20;
    bus.d_write = 1'b1; bus.d_addr = 28'h30; bus.d_wdata = {4{32'hAAAA_AAAA}};
    tick();
    chk("t3_first_owner", bus.mem_owner, 1'b0);
    chk("t3_first_addr",  bus.mem_addr, 28'h20);
    wait_rdy(1'b0, "t3_i_ready_seen", n);
    bus.i_read = 1'b0;
    tick();
    chk("t3_no_write_yet", bus.mem_write, 1'b0);
    tick();
    chk("t3_d_mem_write", bus.mem_write, 1'b1);
    chk("t3_d_mem_addr",  bus.mem_addr, 28'h30);
    chk("t3_d_mem_wdata", bus.mem_wdata, {4{32'hAAAA_AAAA}});
    chk("t3_d_owner",     bus.mem_owner, 1'b1);
    wait_rdy(1'b1, "t3_d_ready_seen", n);
    bus.d_write = 1'b0;
    tick();
    chk("t3_d_rdata_kept", bus.d_rdata, 128'h0);
    chk("t3_i_rdata", bus.i_rdata, {4{32'h2222_2222}});

    // D read+write together: write wins.
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 28'h40; bus.d_wdata = {4{32'h5555_5555}};
    tick();
    chk("t5_mem_write", bus.mem_write, 1'b1);
    chk("t5_mem_read",  bus.mem_read, 1'b0);
    wait_rdy(1'b1, "t5_d_ready_seen", n);
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    tick();
    chk("t5_d_rdata_kept", bus.d_rdata, 128'h0);

    // Both sides keep requesting: owners must alternate I,D,I,D,I,D.
    mem_lat = 2; resp_data = {4{32'h3333_0000}};
    log_n = 0; log_en = 1'b1;
    bus.i_addr = 28'h100; bus.d_addr = 28'h200;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    n_i = 0; n_d = 0;
    for (int c = 0; c < 200 && (n_i < 3 || n_d < 3); c++) begin
      tick();
      if (bus.i_ready) begin n_i++; bus.i_read = 1'b0; end
      else if (n_i < 3) bus.i_read = 1'b1;
      if (bus.d_ready) begin n_d++; bus.d_read = 1'b0; end
      else if (n_d < 3) bus.d_read = 1'b1;
    end
    log_en = 1'b0;
    chk("t4_all_done", (n_i == 3 && n_d == 3), 1'b1);
    chk("t4_grant_count", log_n, 6);
    exp_seq = 6'b10_1010;
    for (int k = 0; k < 6; k++) chk($sformatf("t4_owner%0d", k), own_log[k], exp_seq[k]);
    tick();

    // Reset mid-BUSY, then a late mem_ready: nothing must complete.
    auto_mem = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 28'h50;
    tick();
    chk("t6_busy_read", bus.mem_read, 1'b1);
    tick();
    rst = 1'b1; bus.i_read = 1'b0;
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = {4{32'hFFFF_FFFF}};
    tick();
    tick();
    chk("t6_mem_read", bus.mem_read, 1'b0);
    chk("t6_i_ready",  bus.i_ready, 1'b0);
    chk("t6_d_ready",  bus.d_ready, 1'b0);
    chk("t6_i_rdata",  bus.i_rdata, 128'h0);
    chk("t6_d_rdata",  bus.d_rdata, 128'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
